// File: rtl/access_code_tx.sv
// Serial access-code transmitter. Sends a code one bit at a time, MSB first.
// Each bit comes with a psh strobe; afterwards the block waits for a grant/deny verdict or times out.
module access_code_tx #(
    parameter int CODE_W  = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              led1,
    input  logic              led2,
    output logic              swtch,
    output logic              psh,
    output logic              busy,
    output logic              granted,
    output logic              denied,
    output logic              timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [4:0] BITS     = 5'(CODE_W);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [CODE_W-1:0] shreg;
    logic [CODE_W-1:0] shifted;
    logic [4:0]        bit_cnt;
    logic [3:0]        gap_cnt;
    logic [7:0]        wait_cnt;

    always_comb begin
        shifted = shreg << 1;
    end

    // Outputs are registered and updated together with the state they belong to,
    // so the first psh appears in the cycle right after the accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            swtch    <= 1'b0;
            psh      <= 1'b0;
            busy     <= 1'b0;
            granted  <= 1'b0;
            denied   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SEND;
                        shreg    <= code;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                        wait_cnt <= '0;
                        swtch    <= code[CODE_W-1];
                        psh      <= 1'b1;
                        busy     <= 1'b1;
                        granted  <= 1'b0;
                        denied   <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    psh     <= 1'b0;
                    gap_cnt <= '0;
                    if (bit_cnt != 5'h1f) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (bit_cnt + 5'd1 >= BITS) begin
                        state    <= ST_WAIT;
                        swtch    <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_SEND;
                        shreg <= shifted;
                        swtch <= shifted[CODE_W-1];
                        psh   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    // Deny beats grant, and any verdict beats the timeout on the final count.
                    if (led2) begin
                        denied <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (led1) begin
                        granted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_access_code_tx.sv
// Directed bench for access_code_tx at default parameters (CODE_W=8, GAP=2, TIMEOUT=16).
// Cycle k is the interval after the k-th edge following the accepted start; strobes land on 1,4,...,22.
module tb_access_code_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] code;
    logic       led1;
    logic       led2;
    logic       swtch;
    logic       psh;
    logic       busy;
    logic       granted;
    logic       denied;
    logic       timeout;

    int checks;
    int failures;

    access_code_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .code    (code),
        .led1    (led1),
        .led2    (led2),
        .swtch   (swtch),
        .psh     (psh),
        .busy    (busy),
        .granted (granted),
        .denied  (denied),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, " swtch"}, 32'(swtch), 0);
        checkOutput({tag, " psh"}, 32'(psh), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " granted"}, 32'(granted), 0);
        checkOutput({tag, " denied"}, 32'(denied), 0);
        checkOutput({tag, " timeout"}, 32'(timeout), 0);
    endtask

    // Starts an attempt and checks every cycle of the 8-bit send; returns in cycle 23 (first WAIT cycle).
    // With disturb set, start and led2 are pulsed in cycle 11, the first GAP cycle after bit 4.
    task automatic applyStimulus(input logic [7:0] value, input bit disturb);
        logic [7:0] c;
        int idx;
        c = value;
        code = value;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("flags cleared", 32'({granted, denied, timeout}), 0);
        for (int k = 1; k <= 22; k++) begin
            idx = (k - 1) / 3;
            checkOutput("psh", 32'(psh), 32'(((k - 1) % 3) == 0));
            checkOutput("swtch", 32'(swtch), 32'(c[7 - idx]));
            checkOutput("busy send", 32'(busy), 1);
            if (disturb && k == 11) begin
                start = 1'b1;
                code  = 8'h00;
                led2  = 1'b1;
            end else begin
                start = 1'b0;
                led2  = 1'b0;
            end
            tick();
        end
        checkOutput("wait psh", 32'(psh), 0);
        checkOutput("wait swtch", 32'(swtch), 0);
        checkOutput("wait busy", 32'(busy), 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        code  = 8'h00;
        led1  = 1'b0;
        led2  = 1'b0;
        #1;
        checkAllLow("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkAllLow("idle");

        // Grant three cycles into WAIT; a start in the verdict cycle must not be taken.
        applyStimulus(8'b11010101, 1'b0);
        tick();
        tick();
        tick();
        led1  = 1'b1;
        start = 1'b1;
        tick();
        led1  = 1'b0;
        start = 1'b0;
        checkOutput("grant", 32'(granted), 1);
        checkOutput("grant busy", 32'(busy), 0);
        checkOutput("grant others", 32'({denied, timeout}), 0);
        tick();
        tick();
        checkOutput("grant hold", 32'(granted), 1);
        checkOutput("late start ignored", 32'(busy), 0);

        // Both leds together: deny wins.
        applyStimulus(8'b11010101, 1'b0);
        led1 = 1'b1;
        led2 = 1'b1;
        tick();
        led1 = 1'b0;
        led2 = 1'b0;
        checkOutput("deny", 32'(denied), 1);
        checkOutput("deny granted", 32'(granted), 0);
        checkOutput("deny busy", 32'(busy), 0);

        // No response: timeout exactly 16 cycles after WAIT entry.
        applyStimulus(8'b11010101, 1'b0);
        for (int k = 23; k <= 38; k++) begin
            checkOutput("timeout wait psh", 32'(psh), 0);
            checkOutput("timeout early", 32'(timeout), 0);
            checkOutput("timeout busy", 32'(busy), 1);
            tick();
        end
        checkOutput("timeout", 32'(timeout), 1);
        checkOutput("timeout busy end", 32'(busy), 0);
        checkOutput("timeout others", 32'({granted, denied}), 0);
        tick();

        // Verdict on the final wait cycle beats the timeout.
        applyStimulus(8'b00110011, 1'b0);
        for (int k = 23; k < 38; k++) begin
            tick();
        end
        checkOutput("last cycle no timeout", 32'(timeout), 0);
        led1 = 1'b1;
        tick();
        led1 = 1'b0;
        checkOutput("late grant", 32'(granted), 1);
        checkOutput("late grant timeout", 32'(timeout), 0);
        tick();

        // Start and led2 during bit 4's gap are ignored.
        applyStimulus(8'b11010101, 1'b1);
        led1 = 1'b1;
        tick();
        led1 = 1'b0;
        checkOutput("mid grant", 32'(granted), 1);
        checkOutput("mid denied", 32'(denied), 0);
        tick();

        // Reset in bit 5's gap aborts at once, then a fresh all-ones attempt.
        code  = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 14; k++) begin
            tick();
        end
        checkOutput("pre-reset busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        checkAllLow("async reset");
        tick();
        rst = 1'b0;
        tick();
        checkAllLow("after reset");
        applyStimulus(8'hFF, 1'b0);
        led2 = 1'b1;
        tick();
        led2 = 1'b0;
        checkOutput("ff deny", 32'(denied), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/access_code_tx.md
ACCESS_CODE_TX -- requirements
Module: access_code_tx

Interface
REQ-001 Parameter CODE_W, default 8: number of code bits sent per attempt, range 1..16.
REQ-002 Parameter GAP, default 2: psh-low cycles between bit strobes, range 1..15.
REQ-003 Parameter TIMEOUT, default 16: cycles waited for a verdict, range 1..255.
REQ-004 Clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to send code; sampled only in IDLE.
REQ-007 code  in  CODE_W  code to send; captured on the accepted start.
REQ-008 led1  in  1  grant indication returned by the access controller.
REQ-009 led2  in  1  deny indication returned by the access controller.
REQ-010 swtch  out  1  current code bit presented to the access controller.
REQ-011 psh  out  1  one-cycle strobe qualifying swtch.
REQ-012 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-013 granted  out  1  sticky grant result.
REQ-014 denied  out  1  sticky deny result.
REQ-015 timeout  out  1  sticky no-response result.

Function
REQ-016 The block SHALL be an FSM with states IDLE, SEND, GAP and WAIT; all outputs SHALL be registered.
REQ-017 IDLE: start=1 SHALL load code into a shift register, clear granted, denied and timeout, clear the bit counter, and go to SEND.
REQ-018 SEND SHALL last exactly one cycle with psh=1 and swtch equal to the shift register MSB, so code is sent MSB first.
REQ-019 After SEND, if fewer than CODE_W bits have been sent, the block SHALL go to GAP; after the CODE_W-th bit it SHALL go to WAIT.
REQ-020 GAP SHALL last exactly GAP cycles with psh=0 and swtch holding the last sent bit, then go to SEND with the register shifted left by one.
REQ-021 Timing: an accepted start on edge N SHALL give the first psh high in the cycle after edge N.
REQ-022 Timing: consecutive psh pulses SHALL be exactly GAP+1 cycles apart.
REQ-023 WAIT SHALL count cycles from 0 and set psh=0 and swtch=0.
REQ-024 In WAIT, led1=1 with led2=0 SHALL set granted and go to IDLE.
REQ-025 In WAIT, led2=1 SHALL set denied and go to IDLE; when led1 and led2 are both high, deny wins.
REQ-026 If neither led input is high for TIMEOUT cycles in WAIT, the block SHALL set timeout and go to IDLE.
REQ-027 A verdict that arrives in the same cycle the count reaches TIMEOUT SHALL take priority over timeout.
REQ-028 led1 and led2 SHALL be ignored outside WAIT.
REQ-029 start SHALL be ignored while busy=1, including during WAIT.
REQ-030 start in the same cycle the block returns to IDLE SHALL be ignored; it is accepted only on a later cycle in IDLE.
REQ-031 Exactly one of granted, denied and timeout SHALL be high after any completed attempt, and it SHALL stay high until the next accepted start or reset.
REQ-032 busy SHALL equal 1 in SEND, GAP and WAIT, and 0 in IDLE.
REQ-033 Bit and timeout counters SHALL saturate and SHALL never wrap within an attempt.

Reset
REQ-034 Rst=1 SHALL force IDLE immediately, regardless of Clk.
REQ-035 While Rst=1: swtch, psh, busy, granted, denied and timeout SHALL all be 0, and the shift register and counters SHALL be cleared.
REQ-036 Rst asserted mid-attempt SHALL abort the attempt with no result flag set.
REQ-037 After release, the first accepted start SHALL begin a full CODE_W-bit sequence.

Verification
REQ-038 Defaults; code=8'b11010101; start pulse -> psh pulses in cycles 1,4,7,...,22; swtch=1,1,0,1,0,1,0,1 at those strobes; busy=1 from cycle 1.
REQ-039 After the 8th bit, drive led1=1 three cycles into WAIT -> granted=1 the next cycle; busy=0; granted holds until the next start.
REQ-040 Same send, then led1=1 and led2=1 together -> denied=1 and granted=0.
REQ-041 Same send, then no led activity -> timeout=1 exactly 16 cycles after WAIT entry; psh stays 0 throughout WAIT.
REQ-042 Pulse start again during the 4th bit's GAP -> it is ignored; the sequence and bit count are unchanged.
REQ-043 Assert Rst mid-GAP of bit 5 -> all outputs 0 at once; after release, start with code=8'hFF -> eight psh strobes, all with swtch=1.
